// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC job sequencer.
package cordic_pkg;

  localparam int FLOAT_W = 32;
  localparam logic [FLOAT_W-1:0] FLOAT_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, async active-low reset; head entry is read combinationally.
// full_o is registered and stays high for the whole cycle in which count == DEPTH.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      wdata_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              full_q;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/cordic_sequencer.sv
// Queues float angles, runs one cordic_top job at a time and buffers {sin,cos} results in order.
// Optional WAIT-state watchdog (quiet-NaN result, sticky err) is built when CORDIC_SEQ_WDT_EN is defined.
module cordic_sequencer
  import cordic_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FLOAT_W-1:0] in_angle,
  output logic               cordic_valid,
  output logic [FLOAT_W-1:0] cordic_angle,
  input  logic               cordic_done,
  input  logic [FLOAT_W-1:0] cordic_sin,
  input  logic [FLOAT_W-1:0] cordic_cos,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FLOAT_W-1:0] out_sin,
  output logic [FLOAT_W-1:0] out_cos,
  output logic               busy,
  output logic               err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  seq_state_e state_q, state_d;
  logic [FLOAT_W-1:0] angle_q, angle_d;
  logic done_q, done_rise, wdt_fire;

  logic               ang_push, ang_pop, ang_full, ang_empty;
  logic [FLOAT_W-1:0] ang_rdata;
  logic [CW-1:0]      ang_count;

  logic                 res_push, res_pop, res_full, res_empty;
  logic [2*FLOAT_W-1:0] res_wdata, res_rdata;
  logic [CW-1:0]        res_count;

  logic        inflight, credit_ok;
  logic [CW:0] credit_sum;
  logic        unused_fifo_stat;

  sync_fifo #(.DATA_W(FLOAT_W), .DEPTH(DEPTH)) u_ang_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ang_push),
    .wdata_i (in_angle),
    .pop_i   (ang_pop),
    .rdata_o (ang_rdata),
    .full_o  (ang_full),
    .empty_o (ang_empty),
    .count_o (ang_count)
  );

  sync_fifo #(.DATA_W(2*FLOAT_W), .DEPTH(DEPTH)) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (res_push),
    .wdata_i (res_wdata),
    .pop_i   (res_pop),
    .rdata_o (res_rdata),
    .full_o  (res_full),
    .empty_o (res_empty),
    .count_o (res_count)
  );

  assign unused_fifo_stat = ^{ang_count, res_full};

  assign in_ready  = ~ang_full;
  assign ang_push  = in_valid & in_ready;
  assign out_valid = ~res_empty;
  assign res_pop   = out_valid & out_ready;
  assign {out_sin, out_cos} = res_rdata;

  // Reserving a result slot before issuing means a capture can never hit a full FIFO.
  assign inflight   = (state_q != IDLE);
  assign credit_sum = {1'b0, res_count} + {{CW{1'b0}}, inflight};
  assign credit_ok  = (credit_sum < DEPTH_C);

  assign done_rise = cordic_done & ~done_q;

  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    ang_pop   = 1'b0;
    res_push  = 1'b0;
    res_wdata = {cordic_sin, cordic_cos};
    unique case (state_q)
      IDLE: begin
        if (!ang_empty && credit_ok) begin
          state_d = ISSUE;
          angle_d = ang_rdata;
          ang_pop = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done_rise) begin
          res_push = 1'b1;
          state_d  = IDLE;
        end else if (wdt_fire) begin
          res_push  = 1'b1;
          res_wdata = {FLOAT_QNAN, FLOAT_QNAN};
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      angle_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      done_q  <= cordic_done;
    end
  end

`ifdef CORDIC_SEQ_WDT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WDT_ONE  = WW'(1);

  logic [WW-1:0] wdt_q, wdt_d;
  logic          err_q, err_d;

  // Fires on the edge that would take the count to TIMEOUT, i.e. after TIMEOUT WAIT cycles.
  assign wdt_fire = (state_q == WAIT) && (wdt_q == WDT_LAST);
  assign err_d    = err_q | (wdt_fire & ~done_rise);

  always_comb begin
    wdt_d = wdt_q;
    if (state_q == ISSUE) begin
      wdt_d = '0;
    end else if (state_q == WAIT) begin
      wdt_d = wdt_q + WDT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_q <= '0;
      err_q <= 1'b0;
    end else begin
      wdt_q <= wdt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wdt_fire = 1'b0;
  assign err      = 1'b0;
`endif

  assign cordic_valid = (state_q == ISSUE);
  assign cordic_angle = angle_q;
  assign busy         = inflight | ~ang_empty | ~res_empty;

endmodule

// File: doc/cordic_sequencer.md
Name: cordic_sequencer

Overview:
Upstream/downstream wrapper around cordic_top: buffers incoming float angles, issues them to cordic_top one at a time, and captures each {sin,cos} float pair into a result FIFO. Both sides use valid/ready streams.
Exactly one CORDIC job is in flight at any time. Result order equals angle acceptance order.

Parameters:
DEPTH, 4, entries per FIFO; power of two, >=2.
TIMEOUT, 64, cycles in WAIT before the watchdog fires (only with CORDIC_SEQ_WDT_EN).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
in_valid  in  1  angle offered
in_ready  out  1  angle FIFO not full (registered)
in_angle  in  32  IEEE-754 single angle
cordic_valid  out  1  one-cycle start pulse to cordic_top.valid_in
cordic_angle  out  32  to cordic_top.angle_float; stable from pulse until capture
cordic_done  in  1  from cordic_top.done
cordic_sin  in  32  from cordic_top.sin_float
cordic_cos  in  32  from cordic_top.cos_float
out_valid  out  1  result FIFO not empty
out_ready  in  1  consumer accepts result
out_sin  out  32  head-of-FIFO sin
out_cos  out  32  head-of-FIFO cos
busy  out  1  state != IDLE, or either FIFO non-empty
err  out  1  sticky watchdog flag; cleared only by reset

Behaviour:
- Reset (rst=0, async): both FIFOs empty, state IDLE, watchdog counter 0.
  - in_ready=1; out_valid=0; cordic_valid=0; cordic_angle=0; out_sin=out_cos=0; busy=0; err=0.
- Angle FIFO:
  - Push on in_valid&in_ready.
  - in_ready is registered: 0 when count==DEPTH, even if a pop happens in the same cycle.
- Result FIFO:
  - Pop on out_valid&out_ready; out_sin/out_cos show the head entry combinationally.
  - Simultaneous push+pop is allowed at any count.
- Credit rule: a job may start only if result_count + inflight < DEPTH. This guarantees a captured result never overflows.
- FSM:
  - IDLE -> ISSUE: when angle FIFO is non-empty and credit is available. On this edge, pop the angle into the cordic_angle register.
  - ISSUE -> WAIT: unconditional after one cycle. cordic_valid=1 only during ISSUE.
  - WAIT -> IDLE: on a rising edge of cordic_done (done & ~done_q). On this edge, push {cordic_sin, cordic_cos} into the result FIFO.
  - A level-high cordic_done held over from the previous job is never captured. done_q is updated in every state.
  - cordic_done seen in IDLE or ISSUE is ignored.
- Latency (empty pipe, result space free):
  - Angle accepted at edge E0.
  - cordic_valid high in cycle E1..E2.
  - Result pushed at the edge where the done rise is sampled.
  - out_valid=1 from the following cycle.
  - Back-to-back jobs: the next ISSUE starts the cycle after the WAIT->IDLE edge.
- Reset mid-job: in-flight job and all FIFO contents are discarded. cordic_top shares rst, so no late done survives.

Optional Feature:
CORDIC_SEQ_WDT_EN.
- Defined:
  - The counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no done rise: push sin=cos=32'h7FC00000 (quiet NaN), set err=1, go to IDLE.
  - A done rise in the same cycle the counter reaches TIMEOUT takes priority: normal capture, no err.
- Undefined: no counter logic; err tied to 0; WAIT lasts indefinitely.

Decomposition:
Package cordic_pkg:
- FSM state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2.
- FLOAT_W=32.
- FLOAT_QNAN=32'h7FC00000.

Sub-module sync_fifo #(DATA_W, DEPTH):
- Async active-low reset; provides full, empty, count.
- Instantiated twice: 32-bit angle FIFO and 64-bit {sin,cos} result FIFO.

Test Plan:
1. Single job with a bench CORDIC model (done pulse 10 cycles after valid; returns sin=32'h3F000000, cos=32'h3F5DB3D7). Push in_angle=32'h3F060A92 -> one cordic_valid pulse with cordic_angle=32'h3F060A92; out_valid rises the cycle after done; out_sin/out_cos match; busy returns to 0.
2. Fill and backpressure (out_ready=0, DEPTH=4). Push 10 angles -> exactly 4 CORDIC jobs run; the 5th waits for credit; in_ready drops after 4 more are queued. Then set out_ready=1 -> all 10 results appear in push order, none lost.
3. Level done: the model holds done=1 for 5 cycles, then starts the next job immediately -> only one capture per job, and the second job waits for a fresh done rise.
4. Reset mid-WAIT: rst=0 for 2 cycles during a job -> out_valid=0, in_ready=1, busy=0, err=0. A new angle afterwards is processed normally.
5. With CORDIC_SEQ_WDT_EN, TIMEOUT=64, model never asserts done -> exactly 64 WAIT cycles, then a result of 32'h7FC00000/32'h7FC00000 is pushed and err=1 stays set across further normal jobs.
6. Simultaneous push and pop on both FIFOs at count DEPTH-1 for 20 cycles with random out_ready -> counts stay consistent and no entry is dropped or duplicated.
